pipelined_comparator: RTL and testbench
=======================================

Name: pipelined_comparator

Overview:
- Parametrised, pipelined successor to the combinational COMPARATOR.
- Compares two WIDTH-bit operands under a selectable mode: equality, inequality, signed/unsigned less-than, signed/unsigned greater-or-equal.
- Sits between an operand source and a result consumer using valid/ready handshakes on both sides, with full backpressure.
- Keeps a saturating count of true results for the decode-verification flow.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- STAGES, 2, number of pipeline register stages (>=1); equals latency in cycles.
- CNT_WIDTH, 16, width of the true-result counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  compare mode (cmp_op_t).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- c  output  1  compare result.
- err  output  1  op was illegal.
- true_count  output  CNT_WIDTH  number of consumed results with c=1.
- clear_count  input  1  synchronous clear of true_count.

Behaviour:
- Reset: all stage valid bits, out_valid, c, err and true_count go to 0 immediately on reset assertion. in_ready=1 once reset deasserts. Beats in flight at reset are discarded, never emitted.
- Op encoding:
  - 0 EQ: a==b
  - 1 NE: a!=b
  - 2 LTS: signed a<b
  - 3 LTU: unsigned a<b
  - 4 GES: signed a>=b
  - 5 GEU: unsigned a>=b
  - 6, 7 illegal: c=0, err=1.
- Signed modes treat operands as two's complement WIDTH bits. No sign or zero extension beyond WIDTH.
- Evaluation: the compare is evaluated combinationally on the input beat. {c, err} are registered into stage 0 and delayed through STAGES-1 further registers. The last stage drives the outputs.
- Stage advance:
  - en[i] = !v[i] || en[i+1]; en[STAGES] = out_ready.
  - in_ready = en[0].
  - A stage loads when its enable is high. Its valid bit becomes the upstream valid at that edge.
- Latency: a beat accepted at edge k (in_valid&in_ready) appears on out_* in the cycle after edge k+STAGES-1, provided no stall occurs.
- Throughput: 1 beat per cycle when out_ready is held high.
- Stall: with out_ready=0, the pipeline fills. in_ready falls only when all STAGES slots are full. Outputs hold stable while out_valid=1 and out_ready=0.
- Simultaneous in and out handshake on a full pipe: both complete in the same cycle, and no bubble is inserted.
- Ordering: strict FIFO order; no beat is dropped or duplicated.
- Counter:
  - Increments on each output handshake (out_valid&out_ready) with c=1.
  - Saturates at all-ones and does not wrap.
  - clear_count forces 0 at the next edge. If clear and increment occur in the same cycle, clear wins (result 0).
- err beats still flow and handshake normally, and they never increment the counter.
- a, b and op are sampled only when in_valid&in_ready. Input values outside a handshake are ignored.

Decomposition:
- Package cmp_pkg:
  - cmp_op_t enum (3 bits, values above).
  - Constant CMP_OP_LAST=5.
  - Typedef for the stage payload struct {c, err}.
- Sub-module cmp_core: purely combinational (a, b, op) -> (c, err), parametrised by WIDTH. It is instantiated once at the input.
- The pipeline and counter live in pipelined_comparator.

Test Plan:
- Mode sweep, WIDTH=32, STAGES=2, out_ready=1. Beats: a=5,b=5 EQ -> c=1; a=0xFFFFFFFF,b=1 LTS -> c=1; same operands LTU -> c=0; same GEU -> c=1. Each beat appears 2 cycles after acceptance.
- Illegal op: op=6 with a=b=0 -> c=0, err=1, true_count unchanged.
- Backpressure: hold out_ready=0 and offer 4 beats. Exactly 2 are accepted, and in_ready=0 thereafter. Raise out_ready: all 4 emerge in order, with no drop or duplication.
- Counter: clear, then 10 EQ beats with a==b; true_count=10. Pulse clear_count in the cycle of an 11th true handshake -> true_count=0. Set CNT_WIDTH=4 and send 20 true beats -> true_count=15.
- Reset mid-operation: 2 beats in flight, assert reset asynchronously between edges. out_valid=0 and true_count=0 immediately. After release no stale beat emerges, and in_ready=1.
- Boundaries, WIDTH=8, STAGES=1: a=0x80,b=0x7F GES -> c=0; GEU -> c=1. 1-cycle latency, and back-to-back throughput of 1 beat per cycle.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the pipelined comparator.
package cmp_pkg;

  typedef enum logic [2:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LTS = 3'd2,
    OP_LTU = 3'd3,
    OP_GES = 3'd4,
    OP_GEU = 3'd5
  } cmp_op_t;

  // Highest legal op code; anything above it is reported through err.
  localparam logic [2:0] CMP_OP_LAST = 3'd5;

  typedef struct packed {
    logic c;
    logic err;
  } cmp_payload_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational compare of two WIDTH-bit operands under a selectable mode.
module cmp_core
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             c,
  output logic             err
);

  // Decode the mode and evaluate; codes past the last legal op give c=0, err=1.
  always_comb begin
    c   = 1'b0;
    err = (op > CMP_OP_LAST);
    case (op)
      OP_EQ:   c = (a == b);
      OP_NE:   c = (a != b);
      OP_LTS:  c = ($signed(a) < $signed(b));
      OP_LTU:  c = (a < b);
      OP_GES:  c = ($signed(a) >= $signed(b));
      OP_GEU:  c = (a >= b);
      default: c = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipelined_comparator.sv
// Pipelined comparator: input compare, STAGES-deep valid/ready pipeline with
// full backpressure, and a saturating count of consumed true results.
module pipelined_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 c,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] true_count,
  input  logic                 clear_count
);

  logic         core_c;
  logic         core_err;
  cmp_payload_t core_p;

  logic [STAGES-1:0] stage_v;
  logic [STAGES-1:0] stage_en;
  cmp_payload_t      stage_p [STAGES];

  logic hs_out;

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .a   (a),
    .b   (b),
    .op  (op),
    .c   (core_c),
    .err (core_err)
  );

  assign core_p = '{c: core_c, err: core_err};

  // A stage may load when it, or any stage downstream of it, has room to move.
  // Accumulating from the output end avoids a self-referencing enable vector.
  always_comb begin
    logic room;
    stage_en = '0;
    room     = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      room        = room | ~stage_v[i];
      stage_en[i] = room;
    end
  end

  // Advance valid bits and payloads; payload only updates when a real beat arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_p[i] <= '0;
      end
    end else begin
      if (stage_en[0]) begin
        stage_v[0] <= in_valid;
        if (in_valid) begin
          stage_p[0] <= core_p;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (stage_en[i]) begin
          stage_v[i] <= stage_v[i-1];
          if (stage_v[i-1]) begin
            stage_p[i] <= stage_p[i-1];
          end
        end
      end
    end
  end

  assign in_ready  = stage_en[0];
  assign out_valid = stage_v[STAGES-1];
  assign c         = stage_p[STAGES-1].c;
  assign err       = stage_p[STAGES-1].err;
  assign hs_out    = out_valid & out_ready;

  // Count consumed true results, holding at all-ones; clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      true_count <= '0;
    end else if (clear_count) begin
      true_count <= '0;
    end else if (hs_out && c && !err && (true_count != '1)) begin
      true_count <= true_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipelined_comparator.sv
// Self-checking bench: a 32-bit/2-stage instance and an 8-bit/1-stage/4-bit-count instance.
module tb_pipelined_comparator;

  logic clk = 1'b0;
  logic reset;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_c, p_err, p_clr;
  logic [31:0] p_a, p_b;
  logic [2:0]  p_op;
  logic [15:0] p_cnt;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_c, n_err, n_clr;
  logic [7:0]  n_a, n_b;
  logic [2:0]  n_op;
  logic [3:0]  n_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state for the 32-bit instance
  logic [1:0]  exp_q[$];
  int          mdl_cnt;
  int          exp_cnt_pre;
  bit          hs_in, hs_out, popped_ok, exp_rdy;
  logic [1:0]  popped, obs;
  logic [15:0] obs_cnt;
  logic        obs_rdy;

  always #5 clk = ~clk;

  pipelined_comparator #(.WIDTH(32), .STAGES(2), .CNT_WIDTH(16)) u_wide (
    .clk(clk), .reset(reset), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .op(p_op), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .c(p_c), .err(p_err), .true_count(p_cnt), .clear_count(p_clr)
  );

  pipelined_comparator #(.WIDTH(8), .STAGES(1), .CNT_WIDTH(4)) u_narrow (
    .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .op(n_op), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .c(n_c), .err(n_err), .true_count(n_cnt), .clear_count(n_clr)
  );

  // Plain arithmetic reference: returns {c, err}.
  function automatic logic [1:0] ref_cmp(int w, longint unsigned x, longint unsigned y, int op);
    longint unsigned m;
    longint sx, sy;
    bit r;
    m  = 64'd1 << w;
    x  = x % m;
    y  = y % m;
    sx = (x >= m / 2) ? longint'(x) - longint'(m) : longint'(x);
    sy = (y >= m / 2) ? longint'(y) - longint'(m) : longint'(y);
    case (op)
      0: r = (x == y);
      1: r = (x != y);
      2: r = (sx < sy);
      3: r = (x < y);
      4: r = (sx >= sy);
      5: r = (x >= y);
      default: return 2'b01;
    endcase
    return {r, 1'b0};
  endfunction

  // One cycle of the wide instance: observe at negedge, update model, move to posedge+1.
  task automatic step_p();
    @(negedge clk);
    hs_in       = p_in_valid && p_in_ready;
    hs_out      = p_out_valid && p_out_ready;
    obs         = {p_c, p_err};
    obs_cnt     = p_cnt;
    obs_rdy     = p_in_ready;
    exp_rdy     = (exp_q.size() < 2) || p_out_ready;
    exp_cnt_pre = mdl_cnt;
    popped_ok   = 1'b0;
    popped      = 2'b00;
    if (hs_out && exp_q.size() > 0) begin
      popped    = exp_q.pop_front();
      popped_ok = 1'b1;
    end
    if (p_clr) mdl_cnt = 0;
    else if (popped_ok && popped[1] && mdl_cnt < 65535) mdl_cnt++;
    if (hs_in) exp_q.push_back(ref_cmp(32, 64'(p_a), 64'(p_b), int'(p_op)));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    p_in_valid = 0; p_out_ready = 0; p_clr = 0; p_a = 0; p_b = 0; p_op = 0;
    n_in_valid = 0; n_out_ready = 0; n_clr = 0; n_a = 0; n_b = 0; n_op = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (p_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", p_out_valid); end
    checks++; if (p_cnt !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", p_cnt); end
    checks++; if ({p_c, p_err} !== 2'b00) begin errors++; $display("FAIL reset_c_err got %b want 00", {p_c, p_err}); end
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("FAIL reset_n_out_valid got %b want 0", n_out_valid); end
    reset = 1'b0;
    #2;
    checks++; if (p_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", p_in_ready); end
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL reset_n_in_ready got %b want 1", n_in_ready); end
    exp_q.delete();
    mdl_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_modes();
    logic [31:0] ta[5], tb[5];
    logic [2:0]  top[5];
    logic        te[5];
    int acc_at[5];
    int n_acc, n_out;
    ta  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234};
    tb  = '{32'd5, 32'd1, 32'd1, 32'd1, 32'h1234};
    top = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd1};
    te  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    acc_at = '{0, 0, 0, 0, 0};
    n_acc = 0; n_out = 0;
    p_out_ready = 1;
    for (int s = 0; s < 16 && n_out < 5; s++) begin
      if (n_acc < 5) begin
        p_in_valid = 1; p_a = ta[n_acc]; p_b = tb[n_acc]; p_op = top[n_acc];
      end else p_in_valid = 0;
      step_p();
      if (hs_in && n_acc < 5) begin acc_at[n_acc] = s; n_acc++; end
      if (hs_out) begin
        checks++; if (obs !== {te[n_out], 1'b0}) begin errors++; $display("FAIL mode_result beat %0d got %b want %b", n_out, obs, {te[n_out], 1'b0}); end
        checks++; if (s - acc_at[n_out] != 2) begin errors++; $display("FAIL mode_latency beat %0d got %0d want 2", n_out, s - acc_at[n_out]); end
        n_out++;
      end
    end
    p_in_valid = 0;
    checks++; if (n_out != 5) begin errors++; $display("FAIL mode_count got %0d want 5", n_out); end
  endtask

  task automatic test_illegal();
    int cnt_before, n_out;
    cnt_before = mdl_cnt;
    n_out = 0;
    p_out_ready = 1;
    for (int s = 0; s < 10 && n_out < 2; s++) begin
      if (s == 0) begin p_in_valid = 1; p_a = 0; p_b = 0; p_op = 3'd6; end
      else if (s == 1) begin p_in_valid = 1; p_a = 5; p_b = 5; p_op = 3'd7; end
      else p_in_valid = 0;
      step_p();
      if (hs_out) begin
        checks++; if (obs !== 2'b01) begin errors++; $display("FAIL illegal_result got %b want 01", obs); end
        n_out++;
      end
    end
    p_in_valid = 0;
    step_p();
    checks++; if (n_out != 2) begin errors++; $display("FAIL illegal_count_beats got %0d want 2", n_out); end
    checks++; if (p_cnt !== 16'(cnt_before)) begin errors++; $display("FAIL illegal_true_count got %0d want %0d", p_cnt, cnt_before); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ta[4], tb[4];
    logic [2:0]  top[4];
    logic        te[4];
    int n_acc, n_out;
    ta  = '{32'd3, 32'd3, 32'd9, 32'd1};
    tb  = '{32'd3, 32'd4, 32'd9, 32'd2};
    top = '{3'd0, 3'd0, 3'd5, 3'd4};
    te  = '{1'b1, 1'b0, 1'b1, 1'b0};
    n_acc = 0; n_out = 0;
    p_out_ready = 0;
    for (int s = 0; s < 6; s++) begin
      if (n_acc < 4) begin p_in_valid = 1; p_a = ta[n_acc]; p_b = tb[n_acc]; p_op = top[n_acc]; end
      else p_in_valid = 0;
      step_p();
      if (hs_in) n_acc++;
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL bp_in_ready step %0d got %b want %b", s, obs_rdy, exp_rdy); end
      checks++; if (hs_out) begin errors++; $display("FAIL bp_emit_while_stalled step %0d got 1 want 0", s); end
    end
    checks++; if (n_acc != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", n_acc); end
    checks++; if (p_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b want 0", p_in_ready); end
    checks++; if ({p_out_valid, p_c, p_err} !== {1'b1, te[0], 1'b0}) begin errors++; $display("FAIL bp_hold got %b want %b", {p_out_valid, p_c, p_err}, {1'b1, te[0], 1'b0}); end
    p_out_ready = 1;
    for (int s = 0; s < 20 && n_out < 4; s++) begin
      if (n_acc < 4) begin p_in_valid = 1; p_a = ta[n_acc]; p_b = tb[n_acc]; p_op = top[n_acc]; end
      else p_in_valid = 0;
      step_p();
      if (hs_in) n_acc++;
      if (hs_out) begin
        checks++; if (obs !== {te[n_out], 1'b0}) begin errors++; $display("FAIL bp_order beat %0d got %b want %b", n_out, obs, {te[n_out], 1'b0}); end
        n_out++;
      end
    end
    p_in_valid = 0;
    repeat (3) begin
      step_p();
      checks++; if (hs_out) begin errors++; $display("FAIL bp_duplicate got extra beat %b want none", obs); end
    end
    checks++; if (n_out != 4) begin errors++; $display("FAIL bp_drained got %0d want 4", n_out); end
  endtask

  task automatic test_counter();
    int n_acc, n_out;
    bit done;
    logic [31:0] v;
    p_in_valid = 0; p_out_ready = 1; p_clr = 1;
    step_p();
    p_clr = 0;
    checks++; if (p_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clear got %0d want 0", p_cnt); end
    n_acc = 0; n_out = 0;
    for (int s = 0; s < 40 && n_out < 10; s++) begin
      if (n_acc < 10) begin v = $urandom; p_in_valid = 1; p_a = v; p_b = v; p_op = 3'd0; end
      else p_in_valid = 0;
      step_p();
      if (hs_in) n_acc++;
      if (hs_out) n_out++;
    end
    p_in_valid = 0;
    step_p();
    checks++; if (p_cnt !== 16'd10) begin errors++; $display("FAIL cnt_ten got %0d want 10", p_cnt); end
    v = $urandom;
    p_in_valid = 1; p_a = v; p_b = v; p_op = 3'd0;
    step_p();
    p_in_valid = 0;
    done = 0;
    for (int s = 0; s < 6 && !done; s++) begin
      if (p_out_valid) p_clr = 1;
      step_p();
      if (p_clr) begin done = 1; p_clr = 0; end
    end
    checks++; if (!done) begin errors++; $display("FAIL cnt_eleventh_seen got 0 want 1"); end
    checks++; if (p_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clear_wins got %0d want 0", p_cnt); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 400; s++) begin
      p_in_valid  = ($urandom_range(0, 3) != 0);
      p_out_ready = ($urandom_range(0, 2) != 0);
      p_op        = 3'($urandom_range(0, 7));
      p_a         = $urandom;
      case ($urandom_range(0, 3))
        0: p_b = p_a;
        1: p_b = p_a + 32'd1;
        2: p_b = p_a ^ 32'h8000_0000;
        default: p_b = $urandom;
      endcase
      p_clr = ($urandom_range(0, 30) == 0);
      step_p();
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rand_in_ready step %0d got %b want %b", s, obs_rdy, exp_rdy); end
      if (hs_out) begin
        checks++; if (!popped_ok || obs !== popped) begin errors++; $display("FAIL rand_result step %0d got %b want %b (model had beat %0d)", s, obs, popped, popped_ok); end
      end
      checks++; if (obs_cnt !== 16'(exp_cnt_pre)) begin errors++; $display("FAIL rand_true_count step %0d got %0d want %0d", s, obs_cnt, exp_cnt_pre); end
    end
    p_in_valid = 0; p_out_ready = 1; p_clr = 0;
    for (int s = 0; s < 8; s++) begin
      step_p();
      if (hs_out) begin
        checks++; if (!popped_ok || obs !== popped) begin errors++; $display("FAIL rand_drain got %b want %b", obs, popped); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost_beats got %0d want 0", exp_q.size()); end
    checks++; if (p_out_valid !== 1'b0) begin errors++; $display("FAIL rand_extra_beat got %b want 0", p_out_valid); end
  endtask

  task automatic test_reset_mid();
    p_clr = 0; p_out_ready = 1;
    p_in_valid = 1; p_a = 32'd8; p_b = 32'd8; p_op = 3'd0;
    step_p();
    p_in_valid = 0;
    step_p(); step_p(); step_p();
    p_out_ready = 0;
    p_in_valid = 1; p_a = 32'd1; p_b = 32'd1; p_op = 3'd0;
    step_p(); step_p();
    p_in_valid = 0;
    checks++; if (p_out_valid !== 1'b1 || p_cnt === 16'd0) begin errors++; $display("FAIL rmid_precondition got valid %b count %0d want valid 1 count nonzero", p_out_valid, p_cnt); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (p_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", p_out_valid); end
    checks++; if (p_cnt !== 16'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", p_cnt); end
    #2;
    reset = 1'b0;
    exp_q.delete();
    mdl_cnt = 0;
    @(posedge clk);
    #1;
    checks++; if (p_in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", p_in_ready); end
    p_out_ready = 1;
    for (int s = 0; s < 5; s++) begin
      step_p();
      checks++; if (hs_out) begin errors++; $display("FAIL rmid_stale_beat step %0d got %b want none", s, obs); end
    end
  endtask

  task automatic test_narrow();
    logic [7:0] ta[8], tb[8];
    logic [2:0] top[8];
    logic [1:0] te[8];
    int acc_at[8];
    int n_acc, n_out;
    bit hi, ho;
    logic [1:0] o;
    ta[0] = 8'h80; tb[0] = 8'h7F; top[0] = 3'd4; te[0] = 2'b00;
    ta[1] = 8'h80; tb[1] = 8'h7F; top[1] = 3'd5; te[1] = 2'b10;
    for (int i = 2; i < 8; i++) begin
      ta[i]  = 8'($urandom);
      tb[i]  = (i % 3 == 0) ? ta[i] : 8'($urandom);
      top[i] = 3'($urandom_range(0, 7));
      te[i]  = ref_cmp(8, 64'(ta[i]), 64'(tb[i]), int'(top[i]));
    end
    for (int i = 0; i < 8; i++) acc_at[i] = 0;
    n_acc = 0; n_out = 0;
    n_out_ready = 1; n_clr = 0;
    for (int s = 0; s < 20 && n_out < 8; s++) begin
      if (n_acc < 8) begin n_in_valid = 1; n_a = ta[n_acc]; n_b = tb[n_acc]; n_op = top[n_acc]; end
      else n_in_valid = 0;
      @(negedge clk);
      hi = n_in_valid && n_in_ready;
      ho = n_out_valid && n_out_ready;
      o  = {n_c, n_err};
      if (n_in_valid) begin
        checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL narrow_throughput step %0d got in_ready %b want 1", s, n_in_ready); end
      end
      if (hi && n_acc < 8) begin acc_at[n_acc] = s; n_acc++; end
      if (ho) begin
        checks++; if (o !== te[n_out]) begin errors++; $display("FAIL narrow_result beat %0d got %b want %b", n_out, o, te[n_out]); end
        checks++; if (s - acc_at[n_out] != 1) begin errors++; $display("FAIL narrow_latency beat %0d got %0d want 1", n_out, s - acc_at[n_out]); end
        n_out++;
      end
      @(posedge clk);
      #1;
    end
    n_in_valid = 0;
    checks++; if (n_out != 8) begin errors++; $display("FAIL narrow_count got %0d want 8", n_out); end
    checks++; if (acc_at[7] - acc_at[0] != 7) begin errors++; $display("FAIL narrow_back_to_back got span %0d want 7", acc_at[7] - acc_at[0]); end
  endtask

  task automatic test_saturate();
    int n_acc, n_out, exp_sat;
    logic [7:0] v;
    n_in_valid = 0; n_out_ready = 1; n_clr = 1;
    @(posedge clk);
    #1;
    n_clr = 0;
    checks++; if (n_cnt !== 4'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", n_cnt); end
    exp_sat = 0;
    for (int i = 0; i < 20; i++) exp_sat = (exp_sat == 15) ? 15 : exp_sat + 1;
    n_acc = 0; n_out = 0;
    for (int s = 0; s < 40 && n_out < 20; s++) begin
      if (n_acc < 20) begin v = 8'($urandom); n_in_valid = 1; n_a = v; n_b = v; n_op = 3'd0; end
      else n_in_valid = 0;
      @(negedge clk);
      if (n_in_valid && n_in_ready) n_acc++;
      if (n_out_valid && n_out_ready) n_out++;
      @(posedge clk);
      #1;
    end
    n_in_valid = 0;
    @(posedge clk);
    #1;
    checks++; if (n_out != 20) begin errors++; $display("FAIL sat_beats got %0d want 20", n_out); end
    checks++; if (n_cnt !== 4'(exp_sat)) begin errors++; $display("FAIL sat_count got %0d want %0d", n_cnt, exp_sat); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_modes();
    test_illegal();
    test_backpressure();
    test_counter();
    test_random();
    test_reset_mid();
    test_narrow();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
